// File: rtl/uart_waveform_receiver_if.sv
// Serial input, error clear and the reassembled sample/wave stream of the waveform receiver.
// The receiver takes the master side; the consumer of the sample stream takes the slave side.
interface uart_waveform_receiver_if;
  logic        uart_rx;
  logic        clear_err;
  logic [13:0] sample;
  logic [15:0] sample_index;
  logic        sample_valid;
  logic [15:0] wave_number;
  logic        wave_valid;
  logic        framing_error;
  logic        seq_error;
  logic        busy;

  modport master (
    input  uart_rx, clear_err,
    output sample, sample_index, sample_valid, wave_number, wave_valid,
           framing_error, seq_error, busy
  );

  modport slave (
    output uart_rx, clear_err,
    input  sample, sample_index, sample_valid, wave_number, wave_valid,
           framing_error, seq_error, busy
  );
endinterface

// File: rtl/uart_waveform_receiver.sv
// UART deserialiser that rebuilds waveform records (3-byte sample groups plus a 3-byte trailer)
// into an indexed sample stream and a wave number.
module uart_waveform_receiver #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 3,
  parameter int NUM_SAMPLES  = 2000,
  parameter int IDLE_TIMEOUT = 4096
) (
  input  logic                     clk,
  input  logic                     reset_n,
  uart_waveform_receiver_if.master bus
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int SW = $clog2(STOP_BITS + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [SW-1:0] STOP_LAST = SW'(STOP_BITS - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);
  localparam logic [15:0]   NUM_S     = 16'(NUM_SAMPLES);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_next;
  logic            tick;
  logic            rx_meta, rx_sync, rx_prev;
  logic            rx_fall, rx_rise;
  logic [TW-1:0]   bit_tmr;
  logic [2:0]      bit_cnt;
  logic [SW-1:0]   stop_cnt;
  logic            stop_bad;
  logic [7:0]      shift;
  logic            byte_accept, byte_abort;
  logic [IW-1:0]   idle_tmr;
  logic            timeout_hit;
  logic [1:0]      byte_cnt;
  logic [15:0]     sample_cnt, next_cnt;
  logic [5:0]      hi;
  logic [7:0]      lo;
  logic            in_samples, framing_evt, seq_evt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= bus.uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;
  assign rx_rise = ~rx_prev & rx_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // tick marks the cycle the line is sampled: half a bit into the start bit, then every full bit.
  always_comb begin
    state_next = state;
    tick       = 1'b0;
    case (state)
      IDLE:  if (rx_fall) state_next = START;
      START: if (bit_tmr == HALF_LAST) begin
               tick       = 1'b1;
               state_next = rx_sync ? IDLE : DATA;
             end
      DATA:  if (bit_tmr == BIT_LAST) begin
               tick = 1'b1;
               if (bit_cnt == 3'd7) state_next = STOP;
             end
      STOP:  if (bit_tmr == BIT_LAST) begin
               tick = 1'b1;
               if (stop_cnt == STOP_LAST) state_next = IDLE;
             end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_tmr     <= '0;
      bit_cnt     <= '0;
      stop_cnt    <= '0;
      stop_bad    <= 1'b0;
      shift       <= '0;
      byte_accept <= 1'b0;
      byte_abort  <= 1'b0;
    end else begin
      byte_accept <= 1'b0;
      byte_abort  <= 1'b0;
      if (state == IDLE || tick) bit_tmr <= '0;
      else                       bit_tmr <= bit_tmr + 1'b1;
      if (state == START) begin
        bit_cnt  <= '0;
        stop_cnt <= '0;
        stop_bad <= 1'b0;
      end
      if (state == DATA && tick) begin
        shift   <= {rx_sync, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (state == STOP && tick) begin
        if (stop_cnt == STOP_LAST) begin
          stop_cnt    <= '0;
          stop_bad    <= 1'b0;
          byte_accept <= rx_sync & ~stop_bad;
          byte_abort  <= ~rx_sync | stop_bad;
        end else begin
          stop_cnt <= stop_cnt + 1'b1;
          stop_bad <= stop_bad | ~rx_sync;
        end
      end
    end
  end

  assign bus.busy    = (byte_cnt != 2'd0) || (sample_cnt != 16'd0) || (state != IDLE);
  assign timeout_hit = (state == IDLE) && rx_sync && (idle_tmr == IDLE_LAST) && bus.busy;

  // Idle counter only runs while the line sits high in IDLE; it saturates once the timeout fires.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                       idle_tmr <= '0;
    else if (state != IDLE || !rx_sync || rx_rise)      idle_tmr <= '0;
    else if (idle_tmr != IDLE_LAST)                     idle_tmr <= idle_tmr + 1'b1;
  end

  assign next_cnt    = sample_cnt + 16'd1;
  assign in_samples  = sample_cnt < NUM_S;
  assign framing_evt = (state == STOP) && tick && !rx_sync;
  assign seq_evt     = byte_accept && in_samples && (byte_cnt == 2'd2) && (shift != next_cnt[7:0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt         <= '0;
      sample_cnt       <= '0;
      hi               <= '0;
      lo               <= '0;
      bus.sample       <= '0;
      bus.sample_index <= '0;
      bus.sample_valid <= 1'b0;
      bus.wave_number  <= '0;
      bus.wave_valid   <= 1'b0;
    end else begin
      bus.sample_valid <= 1'b0;
      bus.wave_valid   <= 1'b0;
      if (byte_abort || timeout_hit) begin
        byte_cnt   <= '0;
        sample_cnt <= '0;
      end else if (byte_accept) begin
        case (byte_cnt)
          2'd0: begin
            hi       <= shift[5:0];
            lo       <= shift;
            byte_cnt <= 2'd1;
          end
          2'd1: begin
            lo       <= shift;
            byte_cnt <= 2'd2;
            if (!in_samples) begin
              bus.wave_number <= {lo, shift};
              bus.wave_valid  <= 1'b1;
            end
          end
          default: begin
            byte_cnt <= 2'd0;
            if (in_samples) begin
              bus.sample       <= {hi, lo};
              bus.sample_index <= sample_cnt;
              bus.sample_valid <= 1'b1;
              sample_cnt       <= next_cnt;
            end else begin
              sample_cnt <= '0;
            end
          end
        endcase
      end
    end
  end

  // An error event in the same cycle as clear_err wins, so no event is ever lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.framing_error <= 1'b0;
      bus.seq_error     <= 1'b0;
    end else begin
      bus.framing_error <= (bus.framing_error & ~bus.clear_err) | framing_evt;
      bus.seq_error     <= (bus.seq_error & ~bus.clear_err) | seq_evt;
    end
  end

endmodule
